// File: rtl/video_seg_pkg.sv
// Shared definitions for the segmentation video stages: class count,
// background index, pixel/class types and the class overlay palette.
package video_seg_pkg;

    localparam int CLASSES    = 11;
    localparam int BG_CLASS   = 10;
    localparam int CLASS_BITS = $clog2(CLASSES);

    typedef logic [CLASS_BITS-1:0] class_t;

    // Red occupies the low byte, matching the AXI4-Stream channel order.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    // Entries are written as '{b, g, r}. The background entry is never used.
    localparam rgb_t PALETTE [CLASSES] = '{
        '{8'd0,   8'd0,   8'd255},   // 0: red
        '{8'd0,   8'd128, 8'd255},   // 1: orange
        '{8'd0,   8'd255, 8'd255},   // 2: yellow
        '{8'd0,   8'd255, 8'd0  },   // 3: green
        '{8'd255, 8'd255, 8'd0  },   // 4: cyan
        '{8'd255, 8'd0,   8'd0  },   // 5: blue
        '{8'd255, 8'd0,   8'd128},   // 6: violet
        '{8'd255, 8'd0,   8'd255},   // 7: magenta
        '{8'd255, 8'd255, 8'd255},   // 8: white
        '{8'd128, 8'd128, 8'd128},   // 9: grey
        '{8'd0,   8'd0,   8'd0  }    // 10: background
    };

    // Index values past the table return black instead of reading out of range.
    function automatic rgb_t palette_lookup(input class_t c);
        rgb_t res;
        res = '0;
        for (int i = 0; i < CLASSES; i++) begin
            if (c == class_t'(i)) res = PALETTE[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/video_seg_argmax_tree.sv
// Pipelined argmax tournament. Level 0 registers and tags the N scores,
// each following level halves the field. A sideband bus and the valid
// flag are delayed in lockstep. Everything advances only on cke.
module video_seg_argmax_tree #(
    parameter int N      = 11,
    parameter int W      = 8,
    parameter int IW     = (N > 1) ? $clog2(N) : 1,
    parameter int SB     = 1,
    parameter int STAGES = (N > 1) ? $clog2(N) : 1
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           cke,
    input  logic           in_valid,
    input  logic [N*W-1:0] in_score,
    input  logic [SB-1:0]  in_side,
    output logic           out_valid,
    output logic [W-1:0]   out_score,
    output logic [IW-1:0]  out_index,
    output logic [SB-1:0]  out_side
);

    // Number of live entries at a given tournament level.
    function automatic int cnt_at(input int level);
        return (N + (1 << level) - 1) >> level;
    endfunction

    logic [W-1:0]  sc   [STAGES+1][N];
    logic [IW-1:0] ix   [STAGES+1][N];
    logic [STAGES:0] vld;
    logic [SB-1:0] side [STAGES+1];

    // Level 0: capture the beat and tag every score with its channel index.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the score arrays are pipeline registers, not RAM, so they take the async reset like any flop.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int j = 0; j < N; j++) begin
                sc[0][j] <= '0;
                ix[0][j] <= '0;
            end
        end else if (cke) begin
            for (int j = 0; j < N; j++) begin
                sc[0][j] <= in_score[j*W +: W];
                ix[0][j] <= IW'(j);
            end
        end
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_level
        localparam int PREV = cnt_at(s - 1);
        for (genvar j = 0; j < cnt_at(s); j++) begin : g_node
            if (2 * j + 1 < PREV) begin : g_match
                // Match: the right (higher index) entry wins only on a strictly larger score.
                always_ff @(posedge aclk or posedge areset) begin
                    if (areset) begin
                        sc[s][j] <= '0;
                        ix[s][j] <= '0;
                    end else if (cke) begin
                        if (sc[s-1][2*j+1] > sc[s-1][2*j]) begin
                            sc[s][j] <= sc[s-1][2*j+1];
                            ix[s][j] <= ix[s-1][2*j+1];
                        end else begin
                            sc[s][j] <= sc[s-1][2*j];
                            ix[s][j] <= ix[s-1][2*j];
                        end
                    end
                end
            end else begin : g_bye
                // Odd leftover entry advances unchanged.
                always_ff @(posedge aclk or posedge areset) begin
                    if (areset) begin
                        sc[s][j] <= '0;
                        ix[s][j] <= '0;
                    end else if (cke) begin
                        sc[s][j] <= sc[s-1][2*j];
                        ix[s][j] <= ix[s-1][2*j];
                    end
                end
            end
        end
    end

    // Valid and sideband delay line; bubbles are kept, never collapsed.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld <= '0;
            for (int s = 0; s <= STAGES; s++) side[s] <= '0;
        end else if (cke) begin
            vld     <= {vld[STAGES-1:0], in_valid};
            side[0] <= in_side;
            for (int s = 1; s <= STAGES; s++) side[s] <= side[s-1];
        end
    end

    assign out_valid = vld[STAGES];
    assign out_score = sc[STAGES][0];
    assign out_index = ix[STAGES][0];
    assign out_side  = side[STAGES];

endmodule

// File: rtl/video_seg_argmax_overlay.sv
// Per-pixel argmax of the class scores followed by a palette overlay of
// the winning class onto the RGB pixel. Emits RGB plus the class index.
// One global clock enable stalls the whole pipeline on back-pressure.
module video_seg_argmax_overlay #(
    parameter int CLASSES     = video_seg_pkg::CLASSES,
    parameter int BG_CLASS    = video_seg_pkg::BG_CLASS,
    parameter int DATA_BITS   = 8,
    parameter int NUM         = CLASSES + 3,
    parameter int TUSER_BITS  = 1,
    parameter int CLASS_BITS  = $clog2(CLASSES),
    parameter int TREE_STAGES = $clog2(CLASSES)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      param_enable,
    input  logic [DATA_BITS-1:0]      param_th,
    input  logic [TUSER_BITS-1:0]     s_axi4s_tuser,
    input  logic                      s_axi4s_tlast,
    input  logic [NUM*DATA_BITS-1:0]  s_axi4s_tdata,
    input  logic                      s_axi4s_tvalid,
    output logic                      s_axi4s_tready,
    output logic [TUSER_BITS-1:0]     m_axi4s_tuser,
    output logic                      m_axi4s_tlast,
    output logic [3*DATA_BITS-1:0]    m_axi4s_tdata,
    output logic [CLASS_BITS-1:0]     m_axi4s_tclass,
    output logic                      m_axi4s_tvalid,
    input  logic                      m_axi4s_tready
);
    import video_seg_pkg::*;

    localparam int PIX = 3 * DATA_BITS;
    localparam int SB  = 1 + TUSER_BITS + PIX;

    // Left-align an 8-bit palette channel to DATA_BITS.
    function automatic logic [DATA_BITS-1:0] scale_ch(input logic [7:0] c);
        return DATA_BITS'({c, {DATA_BITS{1'b0}}} >> 8);
    endfunction

    logic cke;
    assign cke            = ~m_axi4s_tvalid | m_axi4s_tready;
    assign s_axi4s_tready = cke;

    logic                  tree_valid;
    logic [DATA_BITS-1:0]  tree_score;
    logic [CLASS_BITS-1:0] tree_index;
    logic [SB-1:0]         tree_side;

    video_seg_argmax_tree #(
        .N      (CLASSES),
        .W      (DATA_BITS),
        .IW     (CLASS_BITS),
        .SB     (SB),
        .STAGES (TREE_STAGES)
    ) u_tree (
        .aclk      (aclk),
        .areset    (areset),
        .cke       (cke),
        .in_valid  (s_axi4s_tvalid),
        .in_score  (s_axi4s_tdata[CLASSES*DATA_BITS-1:0]),
        .in_side   ({s_axi4s_tlast, s_axi4s_tuser, s_axi4s_tdata[NUM*DATA_BITS-1 -: PIX]}),
        .out_valid (tree_valid),
        .out_score (tree_score),
        .out_index (tree_index),
        .out_side  (tree_side)
    );

    rgb_t           pal;
    logic [PIX-1:0] pal_colour;
    assign pal        = palette_lookup(class_t'(tree_index));
    assign pal_colour = {scale_ch(pal.b), scale_ch(pal.g), scale_ch(pal.r)};

    logic                  dec_valid;
    logic                  dec_overlay;
    logic [CLASS_BITS-1:0] dec_index;
    logic [PIX-1:0]        dec_rgb;
    logic [PIX-1:0]        dec_colour;
    logic [TUSER_BITS-1:0] dec_user;
    logic                  dec_last;

    // Decide stage: overlay gate and palette fetch for the winning class.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dec_valid   <= 1'b0;
            dec_overlay <= 1'b0;
            dec_index   <= '0;
            dec_rgb     <= '0;
            dec_colour  <= '0;
            dec_user    <= '0;
            dec_last    <= 1'b0;
        end else if (cke) begin
            dec_valid   <= tree_valid;
            dec_overlay <= param_enable
                           && (tree_index != CLASS_BITS'(BG_CLASS))
                           && (tree_score >= param_th);
            dec_index   <= tree_index;
            dec_rgb     <= tree_side[PIX-1:0];
            dec_colour  <= pal_colour;
            dec_user    <= tree_side[PIX +: TUSER_BITS];
            dec_last    <= tree_side[SB-1];
        end
    end

    logic [PIX-1:0]       blend_rgb;
    logic [DATA_BITS:0]   sum;

    // Blend: average pixel and palette per channel, computed one bit wider.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        blend_rgb = dec_rgb;
        sum       = '0;
        for (int c = 0; c < 3; c++) begin
            sum = {1'b0, dec_rgb[c*DATA_BITS +: DATA_BITS]}
                + {1'b0, dec_colour[c*DATA_BITS +: DATA_BITS]};
            if (dec_overlay) blend_rgb[c*DATA_BITS +: DATA_BITS] = DATA_BITS'(sum >> 1);
        end
    end

    // Output register stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tclass <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (cke) begin
            m_axi4s_tvalid <= dec_valid;
            m_axi4s_tdata  <= blend_rgb;
            m_axi4s_tclass <= dec_index;
            m_axi4s_tuser  <= dec_user;
            m_axi4s_tlast  <= dec_last;
        end
    end

endmodule

// File: tb/tb_video_seg_argmax_overlay.sv
// Directed bench for video_seg_argmax_overlay: a table of single-pixel
// vectors, then streaming, stall and mid-stream reset sequences.
module tb_video_seg_argmax_overlay;

    localparam int NB = 11 * 8 + 24;

    logic          aclk = 1'b0;
    logic          areset;
    logic          param_enable;
    logic [7:0]    param_th;
    logic [0:0]    s_tuser;
    logic          s_tlast;
    logic [NB-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [0:0]    m_tuser;
    logic          m_tlast;
    logic [23:0]   m_tdata;
    logic [3:0]    m_tclass;
    logic          m_tvalid;
    logic          m_tready;

    video_seg_argmax_overlay dut (
        .aclk           (aclk),
        .areset         (areset),
        .param_enable   (param_enable),
        .param_th       (param_th),
        .s_axi4s_tuser  (s_tuser),
        .s_axi4s_tlast  (s_tlast),
        .s_axi4s_tdata  (s_tdata),
        .s_axi4s_tvalid (s_tvalid),
        .s_axi4s_tready (s_tready),
        .m_axi4s_tuser  (m_tuser),
        .m_axi4s_tlast  (m_tlast),
        .m_axi4s_tdata  (m_tdata),
        .m_axi4s_tclass (m_tclass),
        .m_axi4s_tvalid (m_tvalid),
        .m_axi4s_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {b, g, r};
    endfunction

    function automatic logic [NB-1:0] pack_beat(input logic [7:0] base, input int i1, input logic [7:0] v1,
                                                input int i2, input logic [7:0] v2, input logic [23:0] pix);
        logic [NB-1:0] d;
        logic [7:0]    s;
        d = '0;
        for (int i = 0; i < 11; i++) begin
            s = base;
            if (i == i1) s = v1;
            if (i == i2) s = v2;
            d[i*8 +: 8] = s;
        end
        d[88 +: 24] = pix;
        return d;
    endfunction

    // Stream beats: class k%11 wins with 200 over 10, RGB encodes k.
    function automatic logic [23:0] beat_rgb(input int k);
        logic [31:0] kk;
        kk = k;
        return rgb(kk[7:0], {6'd0, kk[9:8]}, 8'hA5);
    endfunction

    function automatic logic [NB-1:0] beat_tdata(input int k);
        return pack_beat(8'd10, k % 11, 8'd200, -1, 8'd0, beat_rgb(k));
    endfunction

    task automatic drive_beat(input int k, input logic user, input logic last);
        s_tdata  = beat_tdata(k);
        s_tuser  = user;
        s_tlast  = last;
        s_tvalid = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  base;
        int          i1;
        logic [7:0]  v1;
        int          i2;
        logic [7:0]  v2;
        logic [23:0] pix;
        logic        en;
        logic [7:0]  th;
        logic [23:0] exp_rgb;
        logic [3:0]  exp_cls;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int sent;
        int got;
        int nxt;
        int bad;
        logic fire_in;

        vecs[0]  = '{"ch3_win",     8'd10, 3,  8'd200, -1, 8'd0,   rgb(100,100,100), 1'b1, 8'd50,  rgb(50,177,50),    4'd3};
        vecs[1]  = '{"tie_2_7",     8'd0,  2,  8'd180, 7,  8'd180, rgb(60,70,80),    1'b1, 8'd50,  rgb(157,162,40),   4'd2};
        vecs[2]  = '{"bg_win",      8'd10, 10, 8'd250, -1, 8'd0,   rgb(11,22,33),    1'b1, 8'd50,  rgb(11,22,33),     4'd10};
        vecs[3]  = '{"below_th",    8'd10, 5,  8'd40,  -1, 8'd0,   rgb(200,150,100), 1'b1, 8'd50,  rgb(200,150,100),  4'd5};
        vecs[4]  = '{"disabled",    8'd10, 4,  8'd200, -1, 8'd0,   rgb(1,2,3),       1'b0, 8'd50,  rgb(1,2,3),        4'd4};
        vecs[5]  = '{"zero_th0",    8'd0,  -1, 8'd0,   -1, 8'd0,   rgb(100,50,0),    1'b1, 8'd0,   rgb(177,25,0),     4'd0};
        vecs[6]  = '{"zero_th1",    8'd0,  -1, 8'd0,   -1, 8'd0,   rgb(100,50,0),    1'b1, 8'd1,   rgb(100,50,0),     4'd0};
        vecs[7]  = '{"max_ch9",     8'd0,  9,  8'd255, -1, 8'd0,   rgb(255,255,255), 1'b1, 8'd255, rgb(191,191,191),  4'd9};
        vecs[8]  = '{"tie_0_10",    8'd0,  0,  8'd255, 10, 8'd255, rgb(255,255,255), 1'b1, 8'd255, rgb(255,127,127),  4'd0};
        vecs[9]  = '{"eq_th_ch8",   8'd10, 8,  8'd50,  -1, 8'd0,   rgb(0,0,0),       1'b1, 8'd50,  rgb(127,127,127),  4'd8};
        vecs[10] = '{"close_ch1",   8'd98, 1,  8'd99,  -1, 8'd0,   rgb(10,20,30),    1'b1, 8'd50,  rgb(132,74,15),    4'd1};
        vecs[11] = '{"tie_6_9",     8'd0,  6,  8'd77,  9,  8'd77,  rgb(50,60,70),    1'b1, 8'd77,  rgb(89,30,162),    4'd6};

        areset = 1'b1; param_enable = 1'b0; param_th = '0;
        s_tuser = '0; s_tlast = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        #23;
        check("reset_tvalid", m_tvalid, 0);
        check("reset_tdata",  m_tdata,  0);
        check("reset_tclass", m_tclass, 0);
        check("reset_tuser",  {m_tuser, m_tlast}, 0);
        @(negedge aclk); areset = 1'b0;
        @(negedge aclk);
        check("idle_tready", s_tready, 1);

        // Table: one pixel at a time through an empty pipeline.
        for (int v = 0; v < 12; v++) begin
            @(negedge aclk);
            param_enable = vecs[v].en;
            param_th     = vecs[v].th;
            s_tdata      = pack_beat(vecs[v].base, vecs[v].i1, vecs[v].v1, vecs[v].i2, vecs[v].v2, vecs[v].pix);
            s_tuser      = '0;
            s_tlast      = 1'b0;
            s_tvalid     = 1'b1;
            @(posedge aclk); lat = 1;
            @(negedge aclk); s_tvalid = 1'b0;
            while (!m_tvalid && lat < 20) begin
                @(posedge aclk); lat++;
                @(negedge aclk);
            end
            check({"lat_", vecs[v].name}, lat, 7);
            check({"rgb_", vecs[v].name}, m_tdata, vecs[v].exp_rgb);
            check({"cls_", vecs[v].name}, m_tclass, vecs[v].exp_cls);
        end

        // Stream of one line with random back-pressure.
        param_enable = 1'b0; param_th = 8'd50;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 6000 && got < 640; cyc++) begin
            @(negedge aclk);
            m_tready = 1'($urandom_range(0, 1));
            if (sent < 640) drive_beat(sent, sent == 0, sent == 639);
            else s_tvalid = 1'b0;
            #1;
            if (m_tvalid && m_tready) begin
                check("stream_cls",  m_tclass, got % 11);
                check("stream_rgb",  m_tdata, beat_rgb(got));
                check("stream_user", m_tuser, got == 0);
                check("stream_last", m_tlast, got == 639);
                got++;
            end
            if (s_tvalid && s_tready) sent++;
        end
        check("stream_count", got, 640);
        @(negedge aclk); s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (10) @(negedge aclk);

        // Fill with the sink stalled: exactly 7 beats fit.
        m_tready = 1'b0; nxt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge aclk);
            drive_beat(nxt, 1'b0, 1'b0);
            #1; fire_in = s_tready;
            @(posedge aclk);
            if (fire_in) nxt++;
            else break;
        end
        check("fill_count", nxt, 7);
        bad = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge aclk); #1;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== beat_rgb(0) || m_tclass !== 4'd0) bad++;
        end
        check("hold_stable", bad, 0);
        // Release: ten beats leave back-to-back while three more enter.
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            m_tready = 1'b1;
            if (nxt < 10) drive_beat(nxt, 1'b0, 1'b0);
            else s_tvalid = 1'b0;
            #1;
            if (m_tvalid !== 1'b1 || m_tdata !== beat_rgb(c) || m_tclass !== 4'(c % 11)) bad++;
            fire_in = s_tvalid && s_tready;
            @(posedge aclk);
            if (fire_in) nxt++;
        end
        check("release_b2b", bad, 0);
        @(negedge aclk); s_tvalid = 1'b0;
        repeat (10) @(negedge aclk);

        // Reset with 7 beats in flight.
        for (int k = 0; k < 7; k++) begin
            @(negedge aclk); drive_beat(300 + k, 1'b0, 1'b0);
        end
        @(posedge aclk);
        #2; areset = 1'b1; #1;
        check("rst_async_tvalid", m_tvalid, 0);
        s_tvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk); areset = 1'b0;
        @(posedge aclk); #1;
        check("rst_release_tready", s_tready, 1);
        @(negedge aclk);
        drive_beat(400, 1'b0, 1'b0);
        @(posedge aclk); lat = 1;
        @(negedge aclk); s_tvalid = 1'b0;
        while (!m_tvalid && lat < 20) begin
            @(posedge aclk); lat++;
            @(negedge aclk);
        end
        check("rst_first_lat", lat, 7);
        check("rst_first_cls", m_tclass, 400 % 11);
        check("rst_first_rgb", m_tdata, beat_rgb(400));
        @(negedge aclk);
        check("rst_alone", m_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
